// File: rtl/ram_arb_2p.sv
// Two-port arbiter in front of a single shared synchronous-read RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (port 0 wins).
module ram_arb_2p #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] din0,
    input  logic [DWIDTH-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    logic [1:0]             w_req;
    logic [1:0]             w_we;
    logic [1:0]             w_gnt;
    logic [1:0]             w_rd;
    logic [1:0][AWIDTH-1:0] w_addr;
    logic [1:0][DWIDTH-1:0] w_din;
    logic [AWIDTH-1:0]      w_ram_addr;
    logic [DWIDTH-1:0]      w_ram_din;
    logic                   w_ram_we;
    logic [1:0]             r_rd_tag;

    assign w_req  = {req1, req0};
    assign w_we   = {we1, we0};
    assign w_addr = {addr1, addr0};
    assign w_din  = {din1, din0};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // r_last1 = 1 means port 1 was granted most recently, so port 0 wins the next tie.
    logic r_last1;

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_last1 <= 1'b1;
        else if (|w_gnt)
            r_last1 <= w_gnt[1];
    end
`endif

    always_comb begin
        w_gnt = '0;
        if (reset_n) begin
            if (&w_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                w_gnt = r_last1 ? 2'b01 : 2'b10;
`else
                w_gnt = 2'b01;
`endif
            end else begin
                w_gnt = w_req;
            end
        end
    end

    // One-hot grant, so OR-ing the masked port fields selects the winner.
    always_comb begin
        w_ram_addr = '0;
        w_ram_din  = '0;
        w_ram_we   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (w_gnt[p]) begin
                w_ram_addr = w_ram_addr | w_addr[p];
                w_ram_din  = w_ram_din  | w_din[p];
                w_ram_we   = w_ram_we   | w_we[p];
            end
        end
    end

    assign w_rd = w_gnt & ~w_we;

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_rd_tag <= 2'b00;
        else
            r_rd_tag <= w_rd;
    end

    assign gnt0     = w_gnt[0];
    assign gnt1     = w_gnt[1];
    assign ram_addr = w_ram_addr;
    assign ram_din  = w_ram_din;
    assign ram_we   = w_ram_we;

    // Gating with reset_n drops a read that was granted just before reset asserted.
    assign rvalid0  = r_rd_tag[0] & reset_n;
    assign rvalid1  = r_rd_tag[1] & reset_n;
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;

endmodule

// File: tb/tb_ram_arb_2p.sv
// Self-checking bench for ram_arb_2p: sync-read RAM stand-in, per-cycle reference model, directed + random stimulus.
module tb_ram_arb_2p;
    localparam int AW = 3;
    localparam int DW = 32;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] din0 = '0, din1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    ram_arb_2p #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // Shared RAM stand-in: one-cycle synchronous read.
    logic [DW-1:0] mem [8] = '{default: '0};
    logic [DW-1:0] dout_q = '0;
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        dout_q <= mem[ram_addr];
    end
    assign ram_dout = dout_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at the falling edge, where inputs are stable for the coming rising edge.
    logic [DW-1:0] shadow [8] = '{default: '0};
    int            mdl_last = 1;
    logic [1:0]    pend_v = '0;
    logic [DW-1:0] pend_d = '0;

    always @(negedge clock) begin
        int            eg;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        eg = -1;
        if (reset_n) begin
            if (req0 && req1) eg = (RR && mdl_last == 0) ? 1 : 0;
            else if (req0)    eg = 0;
            else if (req1)    eg = 1;
        end
        a = (eg == 0) ? addr0 : (eg == 1) ? addr1 : '0;
        d = (eg == 0) ? din0  : (eg == 1) ? din1  : '0;
        w = (eg == 0) ? we0   : (eg == 1) ? we1   : 1'b0;

        chk("m_gnt0", gnt0, eg == 0);
        chk("m_gnt1", gnt1, eg == 1);
        chk("m_ram_we", ram_we, w);
        chk("m_ram_addr", ram_addr, a);
        chk("m_ram_din", ram_din, d);
        chk("m_rvalid0", rvalid0, pend_v[0] & reset_n);
        chk("m_rvalid1", rvalid1, pend_v[1] & reset_n);
        if (pend_v[0] && reset_n) chk("m_rdata0", rdata0, pend_d);
        if (pend_v[1] && reset_n) chk("m_rdata1", rdata1, pend_d);

        pend_v = '0;
        if (!reset_n) begin
            mdl_last = 1;
        end else if (eg >= 0) begin
            if (w) shadow[a] = d;
            else begin
                pend_v[eg] = 1'b1;
                pend_d     = shadow[a];
            end
            mdl_last = eg;
        end
    end

    task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic exp0;
        // Reset state, including a write request that must be blocked
        tick();
        set_in(1, 1, 3'd2, 32'hBAD0BAD0, 1, 1, 3'd4, 32'h1);
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        tick();
        do_reset();

        // Single port write then read
        set_in(1, 1, 3'd3, 32'hDEADBEEF, 0, 0, 0, 0);
        #1;
        chk("sp_wr_gnt0", gnt0, 1);
        chk("sp_wr_ram_we", ram_we, 1);
        tick();
        chk("sp_wr_no_rvalid", rvalid0, 0);
        set_in(1, 0, 3'd3, 0, 0, 0, 0, 0);
        #1;
        chk("sp_rd_gnt0", gnt0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_rvalid0", rvalid0, 1);
        chk("sp_rdata0", rdata0, 32'hDEADBEEF);
        chk("sp_rvalid1", rvalid1, 0);
        tick();

        // Contention, both reads held 4 cycles straight after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp0 = RR ? (i % 2 == 0) : 1'b1;
            set_in(1, 0, 3'd1, 0, 1, 0, 3'd6, 0);
            #1;
            chk($sformatf("ct_gnt0_%0d", i), gnt0, exp0);
            chk($sformatf("ct_gnt1_%0d", i), gnt1, !exp0);
            tick();
            chk($sformatf("ct_rvalid0_%0d", i), rvalid0, exp0);
            chk($sformatf("ct_rvalid1_%0d", i), rvalid1, !exp0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Cross-port read-after-write
        set_in(0, 0, 0, 0, 1, 1, 3'd5, 32'h12345678);
        #1;
        chk("raw_gnt1", gnt1, 1);
        tick();
        set_in(1, 0, 3'd5, 0, 0, 0, 0, 0);
        #1;
        chk("raw_gnt0", gnt0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_rvalid0", rvalid0, 1);
        chk("raw_rdata0", rdata0, 32'h12345678);
        tick();

        // Reset right after a granted read
        set_in(1, 0, 3'd5, 0, 0, 0, 0, 0);
        #1;
        chk("mr_gnt0", gnt0, 1);
        tick();
        reset_n = 1'b0;
        set_in(1, 1, 3'd5, 32'hFFFF0000, 1, 1, 3'd0, 32'h5);
        #1;
        chk("mr_rvalid0", rvalid0, 0);
        chk("mr_rvalid1", rvalid1, 0);
        chk("mr_ram_we", ram_we, 0);
        tick();
        chk("mr_rvalid0_b", rvalid0, 0);
        chk("mr_ram_we_b", ram_we, 0);
        tick();
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 3'd5, 0);
        #1;
        chk("mr_gnt1", gnt1, 1);
        chk("mr_gnt0", gnt0, 0);
        tick();
        chk("mr_rvalid1_after", rvalid1, 1);
        chk("mr_rdata1_after", rdata1, 32'h12345678);
        chk("mr_rvalid0_after", rvalid0, 0);

        // Random traffic; the model checks every cycle
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   AW'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   AW'($urandom_range(0, 7)), $urandom);
            tick();
        end
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arb_2p.md
RAM_ARB_2P -- requirements
Module: ram_arb_2p

Interface
REQ-001 SHALL have parameter AWIDTH, default 3, RAM address width (depth = 1 << AWIDTH).
REQ-002 SHALL have parameter DWIDTH, default 32, RAM data width.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 each, access request from requester 0/1.
REQ-006 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read; qualified by reqN.
REQ-007 SHALL have ports addr0/addr1, input, AWIDTH each, access address.
REQ-008 SHALL have ports din0/din1, input, DWIDTH each, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 each, combinational grant in the request cycle.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1 each, registered read-data-valid.
REQ-011 SHALL have ports rdata0/rdata1, output, DWIDTH each, read data; valid only with rvalidN.
REQ-012 SHALL have ports ram_addr (AWIDTH), ram_din (DWIDTH), ram_we (1), outputs to the shared sync-read RAM.
REQ-013 SHALL have port ram_dout, input, DWIDTH, RAM read data (valid one cycle after address is presented).

Function
REQ-014 SHALL assert at most one of gnt0/gnt1 per cycle; gntN implies reqN.
REQ-015 SHALL grant the sole requester immediately when only one reqN is high.
REQ-016 SHALL, on contention, resolve per the Configuration section; the loser keeps req high and is served in a later cycle.
REQ-017 SHALL drive ram_addr/ram_din/ram_we from the granted port's addrN/dinN/weN in the grant cycle; with no grant: ram_we = 0, ram_addr = 0, ram_din = 0.
REQ-018 SHALL, for a granted read in cycle N, assert rvalidN for exactly cycle N+1 with rdataN = ram_dout.
REQ-019 SHALL NOT assert rvalidN for granted writes.
REQ-020 SHALL support back-to-back accesses: a new grant every cycle, with rvalid pipelined one cycle behind its grant.
REQ-021 SHALL track read ownership in a 2-bit registered tag (read0, read1) so that rdata routing is correct when the grant switches port between consecutive cycles.
REQ-022 SHALL drive rdataN = ram_dout regardless of rvalidN; consumers use rvalidN only.
REQ-023 SHALL guarantee read-after-write ordering: a write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data in N+2.

Reset
REQ-024 SHALL, while reset_n = 0 at a rising edge, clear the read tag, rvalid0/rvalid1 and the round-robin pointer (pointer = requester 0 has priority).
REQ-025 SHALL force gnt0 = gnt1 = 0 and ram_we = 0 in any cycle where reset_n = 0, so that no RAM write occurs during reset.
REQ-026 SHALL discard a read granted in the cycle before reset asserts; rvalid stays 0 after reset.

Configuration
REQ-027 SHALL use macro RAM_ARB_ROUND_ROBIN_EN: when defined, contention is resolved round-robin, granting the port not granted at the most recent grant; the pointer updates only on a grant.
REQ-028 SHALL, when RAM_ARB_ROUND_ROBIN_EN is undefined, use fixed priority (requester 0 always wins); the pointer register is omitted.

Verification
REQ-029 SHALL test single port: req0 write addr 3 = 0xDEADBEEF, then req0 read addr 3 -> gnt0 in both cycles; rvalid0 = 1 and rdata0 = 0xDEADBEEF one cycle after the read grant.
REQ-030 SHALL test contention with macro defined: req0 and req1 both reads, held for 4 cycles after reset -> grants 0,1,0,1; rvalid alternates 0,1,0,1 one cycle later.
REQ-031 SHALL test contention without macro: the same stimulus -> gnt0 for all 4 cycles, gnt1 never asserted.
REQ-032 SHALL test cross-port read-after-write: port1 writes addr 5 = 0x12345678 at cycle N, port0 reads addr 5 at N+1 -> rdata0 = 0x12345678 with rvalid0 at N+2.
REQ-033 SHALL test reset mid-operation: read granted, reset_n = 0 the next cycle -> rvalid0/rvalid1 = 0, ram_we = 0 throughout reset; after release, a req1-only read is granted immediately.
